dm_unit: RTL and testbench

Parametrised data-memory unit for the MIPS pipeline's MEM stage, replacing the fixed 2K-word byte-lane memory. It accepts one load or store request at a time, computes byte enables from access size and address offset, and sign- or zero-extends load data. It detects misaligned accesses and inserts a configurable number of wait states, signalling completion to the pipeline's stall logic with a done pulse.

---
 rtl/dm_unit.sv | 174 +++++++++++++++++
 tb/tb_dm_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_unit.sv
// Data-memory unit for the MEM stage: one load/store in flight, byte-lane enables,
// load extension, misalignment detection and a configurable number of wait states.
module dm_unit #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [31:0]           din,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic [3:0]            be,
  output logic                  addr_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMMIT
  } state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  we_q;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           din_q;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                  cur_we;
  logic [2:0]            cur_op;
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [1:0]            cur_off;
  logic                  cur_err;
  logic [3:0]            cur_be;
  logic [31:0]           load_word;
  logic [31:0]           shifted;
  logic [31:0]           load_data;
  logic [31:0]           store_data;
  logic                  enter_commit;

  // With no wait states the request goes straight to COMMIT on the accepting
  // edge, so lane/error/read decoding must look at the live inputs in IDLE.
  always_comb begin
    cur_we   = we_q;
    cur_op   = op_q;
    cur_addr = addr_q;
    if (state == IDLE) begin
      cur_we   = we;
      cur_op   = op;
      cur_addr = addr;
    end
    cur_off = cur_addr[1:0];

    cur_err = 1'b0;
    cur_be  = 4'b0000;
    case (cur_op[1:0])
      2'b00: cur_be = 4'b0001 << cur_off;
      2'b01: begin
        cur_err = cur_off[0];
        cur_be  = cur_off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        cur_err = (cur_off != 2'b00);
        cur_be  = 4'b1111;
      end
      default: cur_err = 1'b1;
    endcase
    if (cur_err) begin
      cur_be = 4'b0000;
    end

    load_word = mem[cur_addr[ADDR_WIDTH+1:2]];
    shifted   = load_word >> {cur_off, 3'b000};
    case (cur_op[1:0])
      2'b00:   load_data = cur_op[2] ? {24'h000000, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = cur_op[2] ? {16'h0000, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = load_word;
    endcase

    enter_commit = 1'b0;
    if (state == IDLE) begin
      enter_commit = req && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_commit = (count == 4'd0);
    end
  end

  // Store data is replicated across the word; the lane enables pick the target bytes.
  always_comb begin
    case (op_q[1:0])
      2'b00:   store_data = {4{din_q[7:0]}};
      2'b01:   store_data = {2{din_q[15:0]}};
      default: store_data = din_q;
    endcase
  end

  // Control FSM; done/be/addr_error/rdata are registered on the edge entering COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      we_q       <= 1'b0;
      op_q       <= 3'b000;
      addr_q     <= '0;
      din_q      <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'h0;
      be         <= 4'b0000;
      addr_error <= 1'b0;
    end else begin
      if (enter_commit) begin
        state      <= COMMIT;
        done       <= 1'b1;
        be         <= cur_be;
        addr_error <= cur_err;
        if (!cur_we && !cur_err) begin
          rdata <= load_data;
        end
      end
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            op_q   <= op;
            addr_q <= addr;
            din_q  <= din;
            busy   <= 1'b1;
            count  <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end
        end
        COMMIT: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          be         <= 4'b0000;
          addr_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write lands on the edge leaving COMMIT, so a reset during COMMIT cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state == COMMIT && we_q && !addr_error) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: directed vector table, hand-built timing/reset
// sequences and randomized traffic against a lane-level memory model.
module tb_dm_unit;

  logic        clk;
  logic        reset;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [2:0]  op_s    [2];
  logic [12:0] addr_s  [2];
  logic [31:0] din_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] rdata_s [2];
  logic [3:0]  be_s    [2];
  logic        err_s   [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem   [2][2048];
  logic [31:0] model_rdata [2];

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [12:0] addr;
    logic [31:0] din;
    logic [3:0]  exp_be;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [24];

  dm_unit #(.ADDR_WIDTH(11), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .op(op_s[0]),
    .addr(addr_s[0]), .din(din_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .rdata(rdata_s[0]), .be(be_s[0]), .addr_error(err_s[0])
  );

  dm_unit #(.ADDR_WIDTH(11), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .op(op_s[1]),
    .addr(addr_s[1]), .din(din_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .rdata(rdata_s[1]), .be(be_s[1]), .addr_error(err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: lane rules stated directly from access size and offset.
  function automatic logic model_err(input logic [2:0] o, input logic [12:0] a);
    case (o[1:0])
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] o, input logic [12:0] a);
    if (model_err(o, a)) return 4'b0000;
    case (o[1:0])
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] o, input logic [12:0] a,
                                             input logic [31:0] word);
    int          off;
    logic [31:0] v;
    off = int'(a[1:0]);
    v   = word >> (8 * off);
    if (o[1:0] == 2'd0) begin
      v = v & 32'h000000FF;
      if (!o[2] && v[7]) v = v | 32'hFFFFFF00;
    end else if (o[1:0] == 2'd1) begin
      v = v & 32'h0000FFFF;
      if (!o[2] && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] o, input logic [12:0] a,
                                              input logic [31:0] word, input logic [31:0] d);
    logic [3:0]  lanes;
    logic [31:0] r;
    int          src;
    lanes = model_be(o, a);
    r     = word;
    src   = 0;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        r[8*i +: 8] = d[8*src +: 8];
        src++;
      end
    end
    return r;
  endfunction

  // Issues one request, checks latency and outputs against the model, updates the model.
  task automatic applyStimulus(input int inst, input logic w, input logic [2:0] o,
                               input logic [12:0] a, input logic [31:0] d,
                               output logic [3:0] got_be, output logic got_err,
                               output logic [31:0] got_rdata);
    int          lat;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
    lat     = (inst == 0) ? 0 : 3;
    e_err   = model_err(o, a);
    e_be    = model_be(o, a);
    e_rdata = (!w && !e_err) ? model_load(o, a, model_mem[inst][a[12:2]]) : model_rdata[inst];
    got_be    = 4'b0000;
    got_err   = 1'b0;
    got_rdata = 32'h0;

    @(negedge clk);
    req_s[inst]  = 1'b1;
    we_s[inst]   = w;
    op_s[inst]   = o;
    addr_s[inst] = a;
    din_s[inst]  = d;
    @(posedge clk);
    #1;
    req_s[inst] = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("busy_inflight%0d", inst), 32'(busy_s[inst]), 32'd1);
      if (n < lat) begin
        checkOutput($sformatf("done_early%0d", inst), 32'(done_s[inst]), 32'd0);
      end else begin
        checkOutput($sformatf("done_pulse%0d", inst), 32'(done_s[inst]), 32'd1);
        checkOutput($sformatf("be%0d", inst), 32'(be_s[inst]), 32'(e_be));
        checkOutput($sformatf("addr_error%0d", inst), 32'(err_s[inst]), 32'(e_err));
        checkOutput($sformatf("rdata%0d", inst), rdata_s[inst], e_rdata);
        got_be    = be_s[inst];
        got_err   = err_s[inst];
        got_rdata = rdata_s[inst];
      end
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("done_clear%0d", inst), 32'({done_s[inst], busy_s[inst], err_s[inst]}), 32'd0);
    checkOutput($sformatf("be_clear%0d", inst), 32'(be_s[inst]), 32'd0);

    model_rdata[inst] = e_rdata;
    if (w && !e_err) begin
      model_mem[inst][a[12:2]] = model_store(o, a, model_mem[inst][a[12:2]], d);
      $display("[TB] *%08h <= %08h", 32'({a[12:2], 2'b00}), model_mem[inst][a[12:2]]);
    end
  endtask

  initial begin
    logic [3:0]  g_be;
    logic        g_err;
    logic [31:0] g_rdata;
    int          pulses;

    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; op_s[i] = 3'b000; addr_s[i] = '0; din_s[i] = '0;
      model_rdata[i] = 32'h0;
      for (int j = 0; j < 2048; j++) model_mem[i][j] = 32'h0;
    end

    //           we    op      addr    din           be     err   chk   rdata
    vecs[0]  = '{1'b1, 3'b010, 13'h10, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 13'h10, 32'h0,        4'hF, 1'b0, 1'b1, 32'h12345678};
    vecs[2]  = '{1'b1, 3'b000, 13'h13, 32'h000000AB, 4'h8, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 13'h13, 32'h0,        4'h8, 1'b0, 1'b1, 32'hFFFFFFAB};
    vecs[4]  = '{1'b0, 3'b100, 13'h13, 32'h0,        4'h8, 1'b0, 1'b1, 32'h000000AB};
    vecs[5]  = '{1'b0, 3'b010, 13'h10, 32'h0,        4'hF, 1'b0, 1'b1, 32'hAB345678};
    vecs[6]  = '{1'b1, 3'b001, 13'h12, 32'h00008001, 4'hC, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 13'h12, 32'h0,        4'hC, 1'b0, 1'b1, 32'hFFFF8001};
    vecs[8]  = '{1'b0, 3'b101, 13'h12, 32'h0,        4'hC, 1'b0, 1'b1, 32'h00008001};
    vecs[9]  = '{1'b0, 3'b010, 13'h10, 32'h0,        4'hF, 1'b0, 1'b1, 32'h80015678};
    vecs[10] = '{1'b0, 3'b001, 13'h10, 32'h0,        4'h3, 1'b0, 1'b1, 32'h00005678};
    vecs[11] = '{1'b0, 3'b000, 13'h11, 32'h0,        4'h2, 1'b0, 1'b1, 32'h00000056};
    vecs[12] = '{1'b0, 3'b000, 13'h10, 32'h0,        4'h1, 1'b0, 1'b1, 32'h00000078};
    vecs[13] = '{1'b0, 3'b100, 13'h12, 32'h0,        4'h4, 1'b0, 1'b1, 32'h00000001};
    vecs[14] = '{1'b0, 3'b000, 13'h13, 32'h0,        4'h8, 1'b0, 1'b1, 32'hFFFFFF80};
    vecs[15] = '{1'b0, 3'b010, 13'h21, 32'h0,        4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[16] = '{1'b1, 3'b001, 13'h23, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[17] = '{1'b1, 3'b011, 13'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[18] = '{1'b1, 3'b010, 13'h22, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[19] = '{1'b1, 3'b001, 13'h21, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[20] = '{1'b0, 3'b111, 13'h20, 32'h0,        4'h0, 1'b1, 1'b1, 32'hFFFFFF80};
    vecs[21] = '{1'b0, 3'b010, 13'h20, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00000000};
    vecs[22] = '{1'b1, 3'b000, 13'h21, 32'h00000155, 4'h2, 1'b0, 1'b0, 32'h0};
    vecs[23] = '{1'b0, 3'b010, 13'h20, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00005500};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset_outputs%0d", i),
                  32'({busy_s[i], done_s[i], be_s[i], err_s[i]}), 32'd0);
      checkOutput($sformatf("reset_rdata%0d", i), rdata_s[i], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 24; v++) begin
      applyStimulus(0, vecs[v].we, vecs[v].op, vecs[v].addr, vecs[v].din, g_be, g_err, g_rdata);
      checkOutput($sformatf("vec%0d_be", v), 32'(g_be), 32'(vecs[v].exp_be));
      checkOutput($sformatf("vec%0d_err", v), 32'(g_err), 32'(vecs[v].exp_err));
      if (vecs[v].chk_rdata) begin
        checkOutput($sformatf("vec%0d_rdata", v), g_rdata, vecs[v].exp_rdata);
      end
    end

    // req held high across the whole wait window is accepted only once
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; op_s[1] = 3'b010; addr_s[1] = 13'h10; din_s[1] = 32'h0;
    @(posedge clk);
    #1;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("held_busy_c%0d", n + 1), 32'(busy_s[1]), 32'd1);
      checkOutput($sformatf("held_done_c%0d", n + 1), 32'(done_s[1]), (n == 3) ? 32'd1 : 32'd0);
      if (done_s[1]) pulses++;
    end
    @(posedge clk);
    #1;
    checkOutput("held_busy_after", 32'(busy_s[1]), 32'd0);
    req_s[1] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done_s[1] || busy_s[1]) pulses++;
    end
    checkOutput("held_single_accept", 32'(pulses), 32'd1);

    // reset while the store sits in WAIT abandons it
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; op_s[1] = 3'b010; addr_s[1] = 13'h40; din_s[1] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_s[1] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(busy_s[1]), 32'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("midreset_outputs%0d", i),
                  32'({busy_s[i], done_s[i], be_s[i], err_s[i]}), 32'd0);
      checkOutput($sformatf("midreset_rdata%0d", i), rdata_s[i], 32'h0);
      model_rdata[i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_s[1] || busy_s[1]) pulses++;
    end
    checkOutput("abandoned_no_done", 32'(pulses), 32'd0);
    applyStimulus(1, 1'b0, 3'b010, 13'h40, 32'h0, g_be, g_err, g_rdata);
    checkOutput("abandoned_no_write", g_rdata, 32'h00000000);

    for (int t = 0; t < 60; t++) begin
      applyStimulus(t % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    13'($urandom_range(0, 63)), $urandom, g_be, g_err, g_rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
